// File: rtl/match_scan_ctrl.sv
// Frame sequencer for the template-matching array: clear, load template rows, scan pixels,
// drain the array pipeline, then report completion. Match positions are turned into hit pulses.
module match_scan_ctrl #(
    parameter int FRAME_W   = 640,
    parameter int FRAME_H   = 480,
    parameter int TMPL_ROWS = 40,
    parameter int PIPE_LAT  = 4,
    parameter int POS_W     = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             tmpl_req,
    input  logic             tmpl_vld,
    input  logic             pix_vld,
    output logic             array_clr_n,
    output logic             array_ena,
    input  logic [POS_W-1:0] array_xpos,
    input  logic [POS_W-1:0] array_ypos,
    output logic             busy,
    output logic             hit,
    output logic [POS_W-1:0] hit_x,
    output logic [POS_W-1:0] hit_y,
    output logic [7:0]       hit_cnt,
    output logic [POS_W-1:0] pix_x,
    output logic [POS_W-1:0] pix_y,
    output logic             done,
    output logic             found,
    output logic [2:0]       state_dbg
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLR   = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_SCAN  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;

    localparam int RW = $clog2(TMPL_ROWS + 1);
    localparam int DW = $clog2(PIPE_LAT) + 1;

    logic [2:0]         state;
    logic [RW-1:0]      row_cnt;
    logic [DW-1:0]      drain_cnt;
    logic [2*POS_W-1:0] prev_pos;
    logic [2*POS_W-1:0] cur_pos;
    logic               found_q;
    logic               new_hit;
    logic               last_col;
    logic               last_pix;
    logic               kill;

    assign cur_pos  = {array_ypos, array_xpos};
    assign kill     = abort && (state != S_IDLE);
    // An aborted cycle reports nothing, so the held hit values stay as they were.
    assign new_hit  = ((state == S_SCAN) || (state == S_DRAIN)) && (cur_pos != prev_pos) && !abort;
    assign last_col = (pix_x == POS_W'(FRAME_W - 1));
    assign last_pix = last_col && (pix_y == POS_W'(FRAME_H - 1));

    assign busy        = (state != S_IDLE);
    assign array_clr_n = (state != S_CLR);
    assign array_ena   = (state == S_CLR) || (state == S_LOAD);
    assign tmpl_req    = (state == S_LOAD) && (row_cnt < RW'(TMPL_ROWS));
    assign done        = (state == S_FIN);
    // found must already be valid in the FIN cycle, before found_q is updated.
    assign found       = (state == S_FIN) ? (hit_cnt != 8'd0) : found_q;
    assign state_dbg   = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            row_cnt   <= '0;
            drain_cnt <= '0;
            prev_pos  <= '0;
            found_q   <= 1'b0;
            hit       <= 1'b0;
            hit_x     <= '0;
            hit_y     <= '0;
            hit_cnt   <= 8'd0;
            pix_x     <= '0;
            pix_y     <= '0;
        end else begin
            hit <= 1'b0;
            if ((state == S_IDLE) && start && !abort) prev_pos <= '0;
            else prev_pos <= cur_pos;

            if (new_hit) begin
                hit   <= 1'b1;
                hit_x <= array_xpos;
                hit_y <= array_ypos;
                if (hit_cnt != 8'd255) hit_cnt <= hit_cnt + 8'd1;
            end

            if (kill) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            state   <= S_CLR;
                            row_cnt <= '0;
                            pix_x   <= '0;
                            pix_y   <= '0;
                            hit_cnt <= 8'd0;
                            found_q <= 1'b0;
                            hit_x   <= '0;
                            hit_y   <= '0;
                        end
                    end
                    S_CLR: state <= S_LOAD;
                    S_LOAD: begin
                        if (tmpl_vld && (row_cnt < RW'(TMPL_ROWS))) begin
                            row_cnt <= row_cnt + RW'(1);
                            if (row_cnt == RW'(TMPL_ROWS - 1)) state <= S_SCAN;
                        end
                    end
                    S_SCAN: begin
                        if (pix_vld) begin
                            if (last_col) begin
                                pix_x <= '0;
                                pix_y <= pix_y + POS_W'(1);
                            end else begin
                                pix_x <= pix_x + POS_W'(1);
                            end
                            if (last_pix) begin
                                state     <= S_DRAIN;
                                drain_cnt <= DW'(PIPE_LAT - 1);
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (drain_cnt == '0) state <= S_FIN;
                        else drain_cnt <= drain_cnt - DW'(1);
                    end
                    S_FIN: begin
                        found_q <= (hit_cnt != 8'd0);
                        state   <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_match_scan_ctrl.sv
// Randomized bench for match_scan_ctrl: a frame-level model predicts hits and done events into
// a queue that a negedge monitor drains, while the driver checks per-cycle control outputs.
module tb_match_scan_ctrl;
    localparam int FW = 8;
    localparam int FH = 4;
    localparam int TR = 3;
    localparam int PL = 2;
    localparam int NPIX = FW * FH;

    localparam int P_IDLE  = 0;
    localparam int P_CLR   = 1;
    localparam int P_LOAD  = 2;
    localparam int P_SCAN  = 3;
    localparam int P_DRAIN = 4;
    localparam int P_FIN   = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       tmpl_vld = 1'b0;
    logic       pix_vld = 1'b0;
    logic [9:0] array_xpos = '0;
    logic [9:0] array_ypos = '0;
    logic       tmpl_req, array_clr_n, array_ena, busy, hit, done, found;
    logic [9:0] hit_x, hit_y, pix_x, pix_y;
    logic [7:0] hit_cnt;
    logic [2:0] state_dbg;

    logic [15:0] cyc = '0;
    int vectors = 0;
    int miscompares = 0;

    // {cycle[15:0], kind(1=done), found, cnt[7:0], y[9:0], x[9:0]}
    logic [45:0] exp_q[$];

    logic [19:0] m_prev = '0;
    int          m_cnt = 0;
    logic        m_found = 1'b0;
    logic [9:0]  m_hx = '0;
    logic [9:0]  m_hy = '0;

    match_scan_ctrl #(
        .FRAME_W(FW), .FRAME_H(FH), .TMPL_ROWS(TR), .PIPE_LAT(PL), .POS_W(10)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .tmpl_req(tmpl_req), .tmpl_vld(tmpl_vld), .pix_vld(pix_vld),
        .array_clr_n(array_clr_n), .array_ena(array_ena),
        .array_xpos(array_xpos), .array_ypos(array_ypos),
        .busy(busy), .hit(hit), .hit_x(hit_x), .hit_y(hit_y), .hit_cnt(hit_cnt),
        .pix_x(pix_x), .pix_y(pix_y), .done(done), .found(found), .state_dbg(state_dbg)
    );

    // ---- clock / reset ----
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 16'd1;

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish, got running expected finished");
        $fatal(1);
    end

    // ---- scoreboard helpers ----
    function automatic logic [45:0] pack(input logic [15:0] c, input logic k, input logic f,
                                         input logic [7:0] n, input logic [9:0] y, input logic [9:0] x);
        return {c, k, f, n, y, x};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon_pop(input string name, input logic [45:0] act);
        logic [45:0] e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: unexpected event got %0h expected none (cycle %0d)", name, act, cyc);
        end else begin
            e = exp_q.pop_front();
            check(name, {18'd0, act}, {18'd0, e});
        end
    endtask

    // ---- monitor ----
    always @(negedge clk) begin
        if (!rst && hit)  mon_pop("hit_event", pack(cyc, 1'b0, 1'b0, hit_cnt, hit_y, hit_x));
        if (!rst && done) mon_pop("done_event", pack(cyc, 1'b1, found, hit_cnt, hit_y, hit_x));
    end

    // ---- driver tasks ----
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input int ph);
        logic [4:0] e;
        case (ph)
            P_IDLE:  e = 5'b00100;
            P_CLR:   e = 5'b11000;
            P_LOAD:  e = 5'b11110;
            P_FIN:   e = 5'b10101;
            default: e = 5'b10100;
        endcase
        check("ctrl_outs{busy,ena,clr_n,req,done}", {59'd0, busy, array_ena, array_clr_n, tmpl_req, done},
              {59'd0, e});
    endtask

    task automatic pick_pos(input int mode, input int ph, input int sidx,
                            output logic [9:0] nx, output logic [9:0] ny);
        nx = '0;
        ny = '0;
        if (mode == 1) begin
            nx = 10'($urandom_range(1, 2));
            ny = 10'($urandom_range(0, 1));
        end else if (mode == 2) begin
            if (ph == P_SCAN) begin
                if (sidx == 1 || sidx == 2) begin nx = 10'd5; ny = 10'd2; end
                else if (sidx >= 3) begin nx = 10'd7; ny = 10'd3; end
            end else if (ph == P_DRAIN) begin
                nx = 10'd1; ny = 10'd1;
            end
        end
    endtask

    function automatic logic every_hit(input int every, input int idx);
        if (every == 0) return 1'($urandom_range(0, 1));
        return ((idx + 1) % every) == 0;
    endfunction

    task automatic idle_cycles(input int n);
        logic [9:0] nx, ny;
        for (int i = 0; i < n; i++) begin
            check_state(P_IDLE);
            check("idle_hit_cnt", 64'(hit_cnt), 64'(m_cnt));
            check("idle_found", 64'(found), 64'(m_found));
            pick_pos(1, P_IDLE, 0, nx, ny);
            array_xpos = nx;
            array_ypos = ny;
            start = 1'b0;
            abort = 1'($urandom_range(0, 1));
            m_prev = {ny, nx};
            tick();
        end
        abort = 1'b0;
    endtask

    task automatic run_frame(input int tmpl_every, input int pix_every, input int mode,
                             input int abort_pix, input int rst_pix, input int chk_len);
        int ph, rows, pix, drn, sidx, lidx;
        logic [15:0] c0, len;
        logic [9:0] nx, ny;
        logic tv, pv, ab;
        check_state(P_IDLE);
        pick_pos(mode, P_IDLE, 0, nx, ny);
        array_xpos = nx;
        array_ypos = ny;
        start = 1'b1;
        abort = 1'b0;
        m_prev = '0;
        m_cnt = 0;
        m_found = 1'b0;
        m_hx = '0;
        m_hy = '0;
        c0 = cyc;
        tick();
        ph = P_CLR; rows = 0; pix = 0; drn = 0; sidx = 0; lidx = 0;
        while (ph != P_IDLE) begin
            check_state(ph);
            if (ph == P_SCAN) begin
                check("pix_x", 64'(pix_x), 64'(pix % FW));
                check("pix_y", 64'(pix_y), 64'(pix / FW));
            end
            if (ph == P_SCAN && pix == rst_pix) begin
                rst = 1'b1;
                #1;
                check("rst_outs{busy,clr_n,done,found,hit,req,ena}",
                      {57'd0, busy, array_clr_n, done, found, hit, tmpl_req, array_ena}, 64'b0100000);
                check("rst_counters", {26'd0, pix_x, pix_y, hit_cnt, hit_x, hit_y}, 64'd0);
                tick();
                rst = 1'b0;
                start = 1'b0; abort = 1'b0; tmpl_vld = 1'b0; pix_vld = 1'b0;
                array_xpos = '0; array_ypos = '0;
                m_prev = '0; m_cnt = 0; m_found = 1'b0; m_hx = '0; m_hy = '0;
                return;
            end
            if (ph == P_FIN) begin
                exp_q.push_back(pack(cyc, 1'b1, m_cnt != 0, 8'(m_cnt), m_hy, m_hx));
                m_found = (m_cnt != 0);
                if (chk_len != 0) begin
                    len = cyc - c0;
                    check("frame_len", 64'(len), 64'd39);
                end
            end
            pick_pos(mode, ph, sidx, nx, ny);
            tv = (ph == P_LOAD) ? every_hit(tmpl_every, lidx) : 1'($urandom_range(0, 1));
            pv = (ph == P_SCAN) ? every_hit(pix_every, sidx) : 1'($urandom_range(0, 1));
            ab = (ph == P_SCAN) && pv && (pix == abort_pix);
            start = 1'($urandom_range(0, 1));
            abort = ab;
            tmpl_vld = tv;
            pix_vld = pv;
            array_xpos = nx;
            array_ypos = ny;
            if ((ph == P_SCAN || ph == P_DRAIN) && !ab && ({ny, nx} != m_prev)) begin
                if (m_cnt < 255) m_cnt++;
                m_hx = nx;
                m_hy = ny;
                exp_q.push_back(pack(cyc + 16'd1, 1'b0, 1'b0, 8'(m_cnt), ny, nx));
            end
            m_prev = {ny, nx};
            if (ab) ph = P_IDLE;
            else begin
                case (ph)
                    P_CLR: ph = P_LOAD;
                    P_LOAD: begin
                        lidx++;
                        if (tv) begin rows++; if (rows == TR) ph = P_SCAN; end
                    end
                    P_SCAN: begin
                        sidx++;
                        if (pv) begin pix++; if (pix == NPIX) begin ph = P_DRAIN; drn = PL; end end
                    end
                    P_DRAIN: begin drn--; if (drn == 0) ph = P_FIN; end
                    default: ph = P_IDLE;
                endcase
            end
            tick();
        end
        start = 1'b0; abort = 1'b0; tmpl_vld = 1'b0; pix_vld = 1'b0;
    endtask

    task automatic start_with_abort();
        logic [9:0] nx, ny;
        check_state(P_IDLE);
        pick_pos(1, P_IDLE, 0, nx, ny);
        array_xpos = nx;
        array_ypos = ny;
        start = 1'b1;
        abort = 1'b1;
        m_prev = {ny, nx};
        tick();
        start = 1'b0;
        abort = 1'b0;
        idle_cycles(3);
    endtask

    // ---- main sequence ----
    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs{busy,clr_n,done,found,hit,req,ena}",
              {57'd0, busy, array_clr_n, done, found, hit, tmpl_req, array_ena}, 64'b0100000);
        check("reset_counters", {26'd0, pix_x, pix_y, hit_cnt, hit_x, hit_y}, 64'd0);
        rst = 1'b0;
        tick();
        idle_cycles(2);

        run_frame(1, 1, 0, -1, FW * 1 + 3, 0);
        idle_cycles(3);
        run_frame(1, 1, 0, -1, -1, 1);
        idle_cycles(2);
        run_frame(2, 1, 2, -1, -1, 0);
        idle_cycles(2);
        run_frame(1, 3, 1, -1, -1, 0);
        idle_cycles(2);
        for (int f = 0; f < 3; f++) begin
            run_frame(0, 0, 1, -1, -1, 0);
            idle_cycles($urandom_range(1, 3));
        end
        run_frame(1, 1, 1, NPIX - 1, -1, 0);
        idle_cycles(2);
        start_with_abort();

        idle_cycles(3);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/match_scan_ctrl.md
Name: match_scan_ctrl

Overview:
Sequencer for the template-matching processor array. Per frame it clears the array, loads template rows (array_ena high), then streams one frame of pixels in compare mode (array_ena low). It watches the array's match position outputs and reports each new match as a hit pulse. At the end of the frame it signals completion with a found flag and a hit count.

Parameters:
FRAME_W, 640, pixels per line; x counter wraps at FRAME_W-1
FRAME_H, 480, lines per frame
TMPL_ROWS, 40, template rows loaded per frame (one per processor)
PIPE_LAT, 4, cycles after the last pixel before the array result is final
POS_W, 10, width of position buses

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin a frame; honoured only in IDLE
abort  in  1  abandon the current frame
tmpl_req  out  1  request the next template row from template memory
tmpl_vld  in  1  template row present on the array input this cycle
pix_vld  in  1  pixel present on the array input this cycle
array_clr_n  out  1  active-low clear to the array
array_ena  out  1  1 = template load/shift, 0 = compare
array_xpos  in  POS_W  array match x position
array_ypos  in  POS_W  array match y position
busy  out  1  high in any state except IDLE
hit  out  1  one-cycle pulse on a new match
hit_x  out  POS_W  x of the latest hit, held until the next hit
hit_y  out  POS_W  y of the latest hit, held until the next hit
hit_cnt  out  8  hits this frame, saturates at 255
pix_x  out  POS_W  current scan column
pix_y  out  POS_W  current scan line
done  out  1  one-cycle pulse at frame end
found  out  1  at least one hit this frame; valid with done and held until the next start

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0 except array_clr_n=1. Asserting rst mid-frame abandons the frame immediately with no done pulse.
- States: IDLE, CLR, LOAD, SCAN, DRAIN, FIN.
- IDLE: start=1 -> CLR. The same edge zeroes row_cnt, pix_x, pix_y, hit_cnt, found, hit_x, hit_y and the previous-position register. start is ignored in all other states.
- CLR: exactly 1 cycle with array_clr_n=0 and array_ena=1 -> LOAD.
- LOAD: array_ena=1. tmpl_req=1 while row_cnt<TMPL_ROWS. Each cycle with tmpl_vld=1 increments row_cnt. tmpl_vld when row_cnt=TMPL_ROWS is ignored. The edge that accepts row TMPL_ROWS-1 moves to SCAN, so tmpl_req drops on that edge. pix_vld is ignored in LOAD.
- SCAN: array_ena=0, tmpl_req=0. On pix_vld: pix_x increments; at FRAME_W-1 it wraps to 0 and pix_y increments. pix_vld at (FRAME_W-1, FRAME_H-1) moves to DRAIN and loads the drain counter with PIPE_LAT-1. Cycles without pix_vld hold the counters.
- DRAIN: array_ena=0; pix_vld is ignored. The counter decrements each cycle; at 0 -> FIN.
- FIN: done=1 for 1 cycle; found=(hit_cnt!=0) -> IDLE.
- Hit detection runs only in SCAN and DRAIN. The previous-position register holds {array_ypos,array_xpos} and is cleared to 0 on start, matching the array's cleared state. When the inputs differ from it:
  - hit=1 on the next cycle;
  - hit_x/hit_y take the new position;
  - the previous-position register updates;
  - hit_cnt increments, saturating at 255.
- Hits on back-to-back cycles each pulse.
- A match at position (0,0) cannot be distinguished from the cleared state and is not reported.
- Position changes in IDLE, CLR, LOAD and FIN are ignored, but the previous-position register still tracks the inputs.
- abort=1 in any non-IDLE state -> IDLE on the next edge: no done, array_ena=0, hit_x/hit_y/hit_cnt held. abort has priority over every other transition, including the last pixel and the DRAIN exit.
- start and abort together in IDLE: abort wins and the controller stays in IDLE.
- Width rules: pix_x and pix_y are POS_W bits. FRAME_W and FRAME_H must be ≤ 2^POS_W. No arithmetic is performed on array positions; they are compared and copied only.

Test Plan:
Use FRAME_W=8, FRAME_H=4, TMPL_ROWS=3, PIPE_LAT=2.
- Reset mid-SCAN at pix (3,1) -> busy=0, array_clr_n=1, all counters 0, no done pulse.
- start; tmpl_vld=1 continuously; pix_vld=1 continuously; array positions constant 0 -> CLR 1 cycle, LOAD 3 cycles, SCAN 32 cycles, DRAIN 2 cycles, FIN. done is 1 cycle at cycle 39 after start with found=0 and hit_cnt=0.
- tmpl_vld only on every other cycle -> LOAD lasts 6 cycles with tmpl_req high throughout. Extra tmpl_vld pulses after entering SCAN have no effect.
- During SCAN, array positions go (0,0) -> (5,2) -> (5,2) -> (7,3); then during DRAIN -> (1,1) -> hit pulses 3 times. Final hit_x=1, hit_y=1, hit_cnt=3, found=1 at done.
- pix_vld gapped (1 of every 3 cycles) -> pix_x/pix_y advance only on valid cycles; the line wraps 7->0 with pix_y incrementing; DRAIN entered only after the 32nd valid pixel.
- abort asserted together with the last pixel; then start and abort together in IDLE -> return to IDLE with no done, and the controller stays IDLE.
